// File: rtl/cpu_mem.sv
// cpu_mem: 16 x 8-bit CPU-facing word memory with a post-reset INIT sequence.
// After reset the block spends 16 cycles in INIT, writing one word per cycle,
// then serves single-cycle reads (registered data) and writes from the CPU.
// Protocol errors (strobes during INIT, read+write collisions) set a sticky
// err flag. Read and write counters saturate at 255.
//
// Build option: define CPU_MEM_PRELOAD_EN to make INIT load a small boot
// program into words 0..4 (the rest zero); leave it undefined for all-zero
// INIT contents. Timing and behaviour are otherwise identical.

module cpu_mem (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] mem_address,
    input  logic [7:0] mem_data_w,
    input  logic       mem_wr,
    input  logic       mem_rd,
    output logic [7:0] mem_data_r,
    output logic       busy,
    output logic       err,
    output logic [7:0] rd_cnt,
    output logic [7:0] wr_cnt
);

    typedef enum logic {
        INIT  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [3:0] init_ptr;
    logic [7:0] init_word;
    logic [7:0] mem [16];

    logic       init_we;
    logic       rd_accept;
    logic       wr_accept;
    logic       proto_err;

    // State register: reset always restarts the INIT sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: leave INIT once the last word (address 15) has been written.
    always_comb begin
        state_next = state;
        unique case (state)
            INIT: begin
                if (init_ptr == 4'hF) begin
                    state_next = SERVE;
                end
            end
            SERVE: begin
                state_next = SERVE;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    // Output decode: busy flag, accepted accesses and protocol-error detection.
    always_comb begin
        busy      = 1'b0;
        init_we   = 1'b0;
        rd_accept = 1'b0;
        wr_accept = 1'b0;
        proto_err = 1'b0;
        unique case (state)
            INIT: begin
                busy      = 1'b1;
                init_we   = 1'b1;
                proto_err = mem_rd | mem_wr;
            end
            SERVE: begin
                rd_accept = mem_rd & ~mem_wr;
                wr_accept = mem_wr & ~mem_rd;
                proto_err = mem_rd & mem_wr;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // INIT pointer walks 0..15, one word per INIT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            init_ptr <= 4'h0;
        end else if (init_we) begin
            init_ptr <= init_ptr + 4'h1;
        end
    end

    // Word written by INIT at the current pointer.
    always_comb begin
        init_word = 8'h00;
`ifdef CPU_MEM_PRELOAD_EN
        // Boot program: r0=3, r1=4, r0=r0*r1, store r0 to 14, jump 4.
        case (init_ptr)
            4'h0:    init_word = 8'h83;
            4'h1:    init_word = 8'h94;
            4'h2:    init_word = 8'h40;
            4'h3:    init_word = 8'hEE;
            4'h4:    init_word = 8'h04;
            default: init_word = 8'h00;
        endcase
`else
        init_word = 8'h00;
`endif
    end

    // Storage: no reset on the array itself, contents come only from INIT or
    // accepted CPU writes; nothing is written in a reset cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (init_we) begin
                mem[init_ptr] <= init_word;
            end else if (wr_accept) begin
                mem[mem_address] <= mem_data_w;
            end
        end
    end

    // Registered read data, held between accepted reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_data_r <= 8'h00;
        end else if (rd_accept) begin
            mem_data_r <= mem[mem_address];
        end
    end

    // Sticky protocol error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (proto_err) begin
            err <= 1'b1;
        end
    end

    // Saturating access counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt <= 8'h00;
            wr_cnt <= 8'h00;
        end else begin
            if (rd_accept && (rd_cnt != 8'hFF)) begin
                rd_cnt <= rd_cnt + 8'h01;
            end
            if (wr_accept && (wr_cnt != 8'hFF)) begin
                wr_cnt <= wr_cnt + 8'h01;
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem.sv
// tb_cpu_mem: directed and randomized bench for cpu_mem against a
// behavioural model of the memory, counters and error flag.

module tb_cpu_mem;

    logic       clk;
    logic       reset;
    logic [3:0] mem_address;
    logic [7:0] mem_data_w;
    logic       mem_wr;
    logic       mem_rd;
    logic [7:0] mem_data_r;
    logic       busy;
    logic       err;
    logic [7:0] rd_cnt;
    logic [7:0] wr_cnt;

    int assertions;
    int failures;

    // Reference model state.
    logic [7:0] model_mem [16];
    int         model_init_left;
    logic [7:0] model_data_r;
    logic       model_err;
    int         model_rd_cnt;
    int         model_wr_cnt;

    cpu_mem dut (
        .clk         (clk),
        .reset       (reset),
        .mem_address (mem_address),
        .mem_data_w  (mem_data_w),
        .mem_wr      (mem_wr),
        .mem_rd      (mem_rd),
        .mem_data_r  (mem_data_r),
        .busy        (busy),
        .err         (err),
        .rd_cnt      (rd_cnt),
        .wr_cnt      (wr_cnt)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Contents INIT is expected to leave in word a.
    function automatic logic [7:0] bootWord(input int a);
`ifdef CPU_MEM_PRELOAD_EN
        case (a)
            0:       return 8'h83;
            1:       return 8'h94;
            2:       return 8'h40;
            3:       return 8'hEE;
            4:       return 8'h04;
            default: return 8'h00;
        endcase
`else
        return 8'h00;
`endif
    endfunction

    // Advance the model by one clock edge with the given inputs.
    task automatic modelStep(input logic rst, input logic rd, input logic wr,
                             input logic [3:0] a, input logic [7:0] d);
        if (rst) begin
            model_init_left = 16;
            model_data_r    = 8'h00;
            model_err       = 1'b0;
            model_rd_cnt    = 0;
            model_wr_cnt    = 0;
        end else if (model_init_left > 0) begin
            model_mem[16 - model_init_left] = bootWord(16 - model_init_left);
            if (rd || wr) model_err = 1'b1;
            model_init_left = model_init_left - 1;
        end else if (rd && wr) begin
            model_err = 1'b1;
        end else if (rd) begin
            model_data_r = model_mem[a];
            model_rd_cnt = (model_rd_cnt < 255) ? model_rd_cnt + 1 : 255;
        end else if (wr) begin
            model_mem[a] = d;
            model_wr_cnt = (model_wr_cnt < 255) ? model_wr_cnt + 1 : 255;
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model, sample after the edge.
    task automatic applyStimulus(input logic rst, input logic rd, input logic wr,
                                 input logic [3:0] a, input logic [7:0] d);
        reset       = rst;
        mem_rd      = rd;
        mem_wr      = wr;
        mem_address = a;
        mem_data_w  = d;
        @(posedge clk);
        modelStep(rst, rd, wr, a, d);
        #1;
        reset  = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
    endtask

    // Single comparison point.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        assertions++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%02h expected=%02h", tag, observed, expected);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic checkAll(input string tag);
        checkOutput({tag, ".busy"},   {7'b0, busy},   {7'b0, (model_init_left > 0)});
        checkOutput({tag, ".err"},    {7'b0, err},    {7'b0, model_err});
        checkOutput({tag, ".data_r"}, mem_data_r,     model_data_r);
        checkOutput({tag, ".rd_cnt"}, rd_cnt,         8'(model_rd_cnt));
        checkOutput({tag, ".wr_cnt"}, wr_cnt,         8'(model_wr_cnt));
    endtask

    // Reset for one cycle, then idle until busy drops; returns busy cycle count.
    task automatic resetAndInit(output int busy_cycles);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
        busy_cycles = 0;
        while (busy && busy_cycles < 40) begin
            busy_cycles++;
            applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        end
    endtask

    initial begin
        int n;
        assertions      = 0;
        failures        = 0;
        model_init_left = 16;
        model_data_r    = 8'h00;
        model_err       = 1'b0;
        model_rd_cnt    = 0;
        model_wr_cnt    = 0;
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        reset       = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_address = 4'h0;
        mem_data_w  = 8'h00;

        $display("[TB] reset and INIT timing");
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
        checkOutput("reset.busy",   {7'b0, busy}, 8'h01);
        checkOutput("reset.err",    {7'b0, err},  8'h00);
        checkOutput("reset.data_r", mem_data_r,   8'h00);
        checkOutput("reset.rd_cnt", rd_cnt,       8'h00);
        checkOutput("reset.wr_cnt", wr_cnt,       8'h00);
        n = 0;
        while (busy && n < 40) begin
            n++;
            applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
            checkAll($sformatf("init%0d", n));
        end
        checkOutput("init.busy_cycles", 8'(n), 8'd16);
        checkOutput("init.err", {7'b0, err}, 8'h00);

        $display("[TB] reads of INIT contents");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 4'(i), 8'h00);
            checkOutput($sformatf("boot_rd%0d", i), mem_data_r, bootWord(i));
        end
        checkOutput("boot_rd.rd_cnt", rd_cnt, 8'd5);
        checkAll("boot_rd");

        $display("[TB] write then read address 15");
        resetAndInit(n);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'hF, 8'hA5);
        checkOutput("wr15.data_r_held", mem_data_r, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, 8'h00);
        checkOutput("rd15.data_r", mem_data_r, 8'hA5);
        checkOutput("rd15.wr_cnt", wr_cnt, 8'd1);
        checkOutput("rd15.rd_cnt", rd_cnt, 8'd1);
        checkOutput("rd15.err", {7'b0, err}, 8'h00);

        $display("[TB] read/write collision");
        applyStimulus(1'b0, 1'b1, 1'b1, 4'h3, 8'h55);
        checkOutput("coll.err", {7'b0, err}, 8'h01);
        checkOutput("coll.rd_cnt", rd_cnt, 8'd1);
        checkOutput("coll.wr_cnt", wr_cnt, 8'd1);
        checkOutput("coll.data_r", mem_data_r, 8'hA5);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h3, 8'h00);
        checkOutput("coll_rd3.data_r", mem_data_r, bootWord(3));
        checkOutput("coll_rd3.err", {7'b0, err}, 8'h01);
        checkAll("coll_rd3");

        $display("[TB] strobe during INIT and counter saturation");
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
        n = 0;
        repeat (4) begin
            n++;
            applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        end
        n++;
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h1, 8'h00);
        checkOutput("init_strobe.err", {7'b0, err}, 8'h01);
        checkOutput("init_strobe.rd_cnt", rd_cnt, 8'h00);
        while (busy && n < 40) begin
            n++;
            applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        end
        checkOutput("init_strobe.busy_cycles", 8'(n), 8'd16);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 4'($urandom_range(0, 15)), 8'h00);
            if (i == 254) checkOutput("rd_sat.at255", rd_cnt, 8'd255);
        end
        checkOutput("rd_sat.final", rd_cnt, 8'd255);
        checkAll("rd_sat");
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 4'($urandom_range(0, 15)), 8'($urandom));
        end
        checkOutput("wr_sat.final", wr_cnt, 8'd255);
        checkAll("wr_sat");

        $display("[TB] reset during INIT discards earlier write");
        applyStimulus(1'b0, 1'b0, 1'b1, 4'h2, 8'h7F);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
        repeat (7) applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h2, 8'h7F);
        n = 0;
        while (busy && n < 40) begin
            n++;
            applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        end
        checkOutput("mid_reset.busy_cycles", 8'(n), 8'd16);
        checkOutput("mid_reset.err", {7'b0, err}, 8'h00);
        checkOutput("mid_reset.rd_cnt", rd_cnt, 8'h00);
        checkOutput("mid_reset.wr_cnt", wr_cnt, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h2, 8'h00);
        checkOutput("mid_reset.rd2", mem_data_r, bootWord(2));

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 79) == 0),
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 2) == 0),
                          4'($urandom_range(0, 15)),
                          8'($urandom));
            checkAll($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/cpu_mem.md
CPU_MEM -- requirements
Module: cpu_mem

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, reset, sampled on the rising edge of clk.
REQ-002 Ports SHALL be, one per line:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous active-high reset
- mem_address  input  4  word address from the CPU
- mem_data_w  input  8  write data from the CPU
- mem_wr  input  1  write strobe, active high
- mem_rd  input  1  read strobe, active high
- mem_data_r  output  8  registered read data to the CPU
- busy  output  1  high while the post-reset init sequence runs
- err  output  1  sticky protocol-error flag
- rd_cnt  output  8  count of accepted reads
- wr_cnt  output  8  count of accepted writes

Function
REQ-003 Storage SHALL be 16 words of 8 bits, addressed by mem_address[3:0]; no wrap logic is needed beyond 4-bit addressing.
REQ-004 The block SHALL have a two-state machine: INIT and SERVE.
- Reset enters INIT with an internal 4-bit init pointer at 0.
- INIT writes one word per cycle at the pointer (0..15), increments the pointer, and enters SERVE after writing address 15, i.e. 16 cycles in INIT.
REQ-005 busy SHALL be 1 exactly while the state is INIT and 0 in SERVE.
REQ-006 In SERVE, a cycle with mem_rd=1 and mem_wr=0 SHALL load mem_data_r with word[mem_address] at that edge (1-cycle latency) and increment rd_cnt.
REQ-007 In SERVE, a cycle with mem_wr=1 and mem_rd=0 SHALL write mem_data_w to word[mem_address] at that edge and increment wr_cnt; mem_data_r is unchanged.
REQ-008 Strobes are level-qualified per cycle: a strobe held for N cycles SHALL be N accesses.
REQ-009 mem_data_r SHALL hold its last value on all cycles without an accepted read.
REQ-010 mem_rd=1 and mem_wr=1 in the same cycle SHALL cause the following:
- no write and no read
- no counter change
- err set to 1
REQ-011 Any strobe while in INIT SHALL be ignored and SHALL set err to 1; the INIT sequence continues unaffected.
REQ-012 err SHALL stay at 1 until reset.
REQ-013 rd_cnt and wr_cnt SHALL saturate at 255 and not wrap.

Reset
REQ-014 Reset SHALL set the following:
- mem_data_r = 0x00, err = 0, rd_cnt = 0, wr_cnt = 0
- busy = 1 from the first cycle after reset
- state = INIT, init pointer = 0
REQ-015 Reset asserted mid-INIT or mid-access SHALL restart INIT from address 0; no partial write is completed in the reset cycle.
REQ-016 Memory contents SHALL be defined only by the INIT sequence, not by the reset edge itself.

Configuration
REQ-017 Macro CPU_MEM_PRELOAD_EN SHALL select the INIT contents.
- Defined: INIT writes the fixed boot program, words 0..15 = 0x83, 0x94, 0x40, 0xEE, 0x04, then 0x00 for words 5..15. This program means: r0=3, r1=4, r0=r0*r1, store r0 to 14, jump 4.
- Undefined: INIT writes 0x00 to all 16 words.
- The INIT timing, busy behaviour and all other behaviour SHALL be identical in both builds.

Verification
REQ-018 Assert reset for 1 cycle, then release and hold strobes low -> busy=1 for exactly 16 cycles, then busy=0; err=0; counters=0; mem_data_r=0x00.
REQ-019 After INIT with CPU_MEM_PRELOAD_EN defined, read addresses 0..4 -> mem_data_r = 0x83, 0x94, 0x40, 0xEE, 0x04, each one cycle after its strobe; rd_cnt=5. Without the macro, the same reads -> 0x00 each.
REQ-020 Write 0xA5 to address 15 (1-cycle mem_wr), then read address 15 -> mem_data_r=0xA5 on the edge after the read cycle; wr_cnt=1, rd_cnt=1; err=0.
REQ-021 Assert mem_rd and mem_wr together at address 3 with data 0x55, then read address 3 -> err=1, original contents unchanged, counters unchanged by the collision cycle.
REQ-022 Strobe mem_rd during INIT cycle 5 -> err=1, INIT still completes at cycle 16; then hold mem_rd for 300 cycles -> rd_cnt stops at 255.
REQ-023 Write 0x7F to address 2, then assert reset during INIT cycle 8, then run a full INIT -> address 2 holds its INIT value, not 0x7F; err=0; counters=0.
